// File: rtl/crc_frame_feeder.sv
// crc_frame_feeder
//   Framing stage in front of the CRC calculator. Accepts a byte stream
//   (valid/ready, sof + length on the first beat), buffers tagged bytes in a
//   FIFO and replays them on the CRC push interface (first/last/valid/data),
//   leaving at least GAP idle cycles after every frame.
//
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   s_valid    upstream byte valid        s_ready   feeder can take a byte
//   s_data     upstream byte              s_sof     first byte of a frame
//   s_len_m1   frame length minus 1 (sampled on accepted sof beats)
//   hold       downstream stall, blocks pops
//   first/last/valid/data   CRC push interface
//   frame_cnt  frames fully emitted (wraps)
//   err_nosof  sticky: non-sof beat outside a frame
//   err_sof    sticky: sof inside a frame
//   busy       FIFO non-empty, input frame open or output in gap
//
// state    | meaning
// IN_IDLE  | waiting for a sof beat; non-sof beats are dropped
// IN_FRAME | frame open, rem bytes still to come after the current one
// OUT_IDLE | popping one entry per cycle while FIFO non-empty and hold=0
// OUT_GAP  | inter-frame gap, gap_cnt counts down to terminal count 1

module crc_frame_feeder #(
   parameter int DEPTH = 16,
   parameter int LEN_W = 8,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_sof,
   input  logic [LEN_W-1:0] s_len_m1,
   input  logic             hold,
   output logic             first,
   output logic             last,
   output logic             valid,
   output logic [7:0]       data,
   output logic [15:0]      frame_cnt,
   output logic             err_nosof,
   output logic             err_sof,
   output logic             busy
);

   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

   typedef enum logic {IN_IDLE, IN_FRAME} in_state_t;
   typedef enum logic {OUT_IDLE, OUT_GAP} out_state_t;

   logic [9:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             full, empty;

   in_state_t        in_state, in_next;
   logic [LEN_W-1:0] rem, rem_next;
   logic             accept, push, push_first, push_last;
   logic             set_nosof, set_sof;

   out_state_t       out_state, out_next;
   logic [GW-1:0]    gap_cnt, gap_next;
   logic             pop;
   logic [9:0]       pop_entry;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   // Held low during reset so nothing is accepted into a FIFO being cleared.
   assign s_ready   = rst & ~full;
   assign accept    = s_valid & s_ready;
   assign pop_entry = mem[rd_ptr];
   assign busy      = ~empty | (in_state == IN_FRAME) | (out_state != OUT_IDLE);

   // Input framing
   always_comb begin
      in_next    = in_state;
      rem_next   = rem;
      push       = 1'b0;
      push_first = 1'b0;
      push_last  = 1'b0;
      set_nosof  = 1'b0;
      set_sof    = 1'b0;
      if (accept) begin
         case (in_state)
            IN_IDLE: begin
               if (s_sof) begin
                  push       = 1'b1;
                  push_first = 1'b1;
                  rem_next   = s_len_m1;
                  if (s_len_m1 == '0) push_last = 1'b1;
                  else                in_next   = IN_FRAME;
               end else begin
                  set_nosof = 1'b1;
               end
            end
            IN_FRAME: begin
               push     = 1'b1;
               set_sof  = s_sof;
               rem_next = rem - LEN_W'(1);
               if (rem == LEN_W'(1)) begin
                  push_last = 1'b1;
                  in_next   = IN_IDLE;
               end
            end
            default: in_next = IN_IDLE;
         endcase
      end
   end

   // Output sequencing
   always_comb begin
      out_next = out_state;
      gap_next = gap_cnt;
      pop      = 1'b0;
      case (out_state)
         OUT_IDLE: begin
            pop = ~empty & ~hold;
            if (pop && pop_entry[8] && (GAP > 0)) begin
               out_next = OUT_GAP;
               gap_next = GW'(GAP);
            end
         end
         OUT_GAP: begin
            // hold is deliberately ignored here: the gap runs on regardless
            gap_next = gap_cnt - GW'(1);
            if (gap_cnt == GW'(1)) out_next = OUT_IDLE;
         end
         default: out_next = OUT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_state  <= IN_IDLE;
         rem       <= '0;
         out_state <= OUT_IDLE;
         gap_cnt   <= '0;
      end else begin
         in_state  <= in_next;
         rem       <= rem_next;
         out_state <= out_next;
         gap_cnt   <= gap_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_first, push_last, s_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first     <= 1'b0;
         last      <= 1'b0;
         valid     <= 1'b0;
         data      <= 8'h00;
         frame_cnt <= 16'h0000;
         err_nosof <= 1'b0;
         err_sof   <= 1'b0;
      end else begin
         if (pop) begin
            valid <= 1'b1;
            first <= pop_entry[9];
            last  <= pop_entry[8];
            data  <= pop_entry[7:0];
            if (pop_entry[8]) frame_cnt <= frame_cnt + 16'd1;
         end else begin
            valid <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
         end
         if (set_nosof) err_nosof <= 1'b1;
         if (set_sof)   err_sof   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crc_frame_feeder.sv
// Testbench for crc_frame_feeder: directed scenarios plus randomized frames,
// checked against a queue-based model of the expected output beat stream.
module tb_crc_frame_feeder;

   localparam int DEPTH = 16;
   localparam int LEN_W = 8;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [7:0]       s_data = 8'h00;
   logic             s_sof = 1'b0;
   logic [LEN_W-1:0] s_len_m1 = '0;
   logic             hold = 1'b0;
   logic             first, last, valid;
   logic [7:0]       data;
   logic [15:0]      frame_cnt;
   logic             err_nosof, err_sof, busy;

   crc_frame_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .s_len_m1(s_len_m1), .hold(hold),
      .first(first), .last(last), .valid(valid), .data(data),
      .frame_cnt(frame_cnt), .err_nosof(err_nosof), .err_sof(err_sof),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected {first,last,data} stream, sticky flags, frame count
   logic [9:0] exp_q[$];
   int         bytes_left = 0;
   bit         m_nosof = 0;
   bit         m_sof = 0;
   int         m_fc = 0;
   int         since_last = GAP;
   bit         hold_prev = 0;
   int         cyc = 0;
   int         acc_cyc[$];
   int         out_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         bytes_left = 0;
         m_nosof    = 0;
         m_sof      = 0;
         m_fc       = 0;
         since_last = GAP;
         hold_prev  = 0;
         chk("ready_in_reset", 32'(s_ready), 32'd0);
      end else begin
         chk("err_nosof", 32'(err_nosof), 32'(m_nosof));
         chk("err_sof", 32'(err_sof), 32'(m_sof));
         if (hold_prev) chk("valid_after_hold", 32'(valid), 32'd0);
         if (valid) begin
            if (exp_q.size() == 0) chk("spurious_beat", 32'(valid), 32'd0);
            else chk("beat", 32'({first, last, data}), 32'(exp_q.pop_front()));
            if (first) chk("gap_respected", 32'(since_last >= GAP), 32'd1);
            if (last) m_fc++;
            out_cyc.push_back(cyc);
         end else begin
            chk("idle_tags", 32'({first, last}), 32'd0);
         end
         if (valid && last) since_last = 0;
         else if (since_last < 1000) since_last++;
         chk("frame_cnt", 32'(frame_cnt), 32'(m_fc[15:0]));
         hold_prev = hold;
         if (s_valid && s_ready) begin
            acc_cyc.push_back(cyc);
            if (bytes_left == 0) begin
               if (s_sof) begin
                  bytes_left = int'(s_len_m1) + 1;
                  exp_q.push_back({1'b1, (bytes_left == 1), s_data});
                  bytes_left--;
               end else begin
                  m_nosof = 1;
               end
            end else begin
               if (s_sof) m_sof = 1;
               bytes_left--;
               exp_q.push_back({1'b0, (bytes_left == 0), s_data});
            end
         end
      end
   end

   // Drive one beat and wait (bounded) until it is accepted.
   task automatic send(input logic [7:0] d, input logic sof, input int lm1, input bit rnd_hold);
      bit ok = 0;
      s_valid  = 1'b1;
      s_data   = d;
      s_sof    = sof;
      s_len_m1 = LEN_W'(lm1);
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (s_ready) ok = 1;
         @(posedge clk);
         #1;
         if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (!ok) chk("send_timeout", 32'(s_ready), 32'd1);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_outs", 32'({first, last, data}), 32'd0);
      chk("rst_fc", 32'(frame_cnt), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      rst = 1'b1;
      idle(2);

      // 1: single 4-byte frame, latency and back-to-back output
      acc_cyc.delete(); out_cyc.delete();
      send(8'hA5, 1'b1, 3, 0);
      send(8'hA3, 1'b0, 0, 0);
      send(8'hA0, 1'b0, 0, 0);
      send(8'hC1, 1'b0, 0, 0);
      idle(4);
      chk("t1_nbeats", 32'(out_cyc.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (out_cyc.size() > i && acc_cyc.size() > 0)
            chk("t1_latency", 32'(out_cyc[i]), 32'(acc_cyc[0] + 2 + i));
      idle(3);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_fc", 32'(frame_cnt), 32'd1);

      // 2: back-to-back frames, exact gap
      acc_cyc.delete(); out_cyc.delete();
      send(8'h12, 1'b1, 1, 0);
      send(8'h34, 1'b0, 0, 0);
      send(8'h56, 1'b1, 1, 0);
      send(8'h78, 1'b0, 0, 0);
      idle(8);
      chk("t2_nbeats", 32'(out_cyc.size()), 32'd4);
      if (out_cyc.size() == 4) chk("t2_gap", 32'(out_cyc[2] - out_cyc[1]), 32'(GAP + 1));
      chk("t2_fc", 32'(frame_cnt), 32'd3);

      // 3: backpressure fills the FIFO, then drain a 32-byte frame
      hold = 1'b1;
      idle(1);
      for (int i = 0; i < 16; i++) send(8'(8'h40 + i), (i == 0), 31, 0);
      chk("t3_full_ready", 32'(s_ready), 32'd0);
      chk("t3_held_valid", 32'(valid), 32'd0);
      hold = 1'b0;
      for (int i = 16; i < 32; i++) send(8'(8'h40 + i), 1'b0, 0, 0);
      idle(40);
      chk("t3_drained", 32'(exp_q.size()), 32'd0);
      chk("t3_fc", 32'(frame_cnt), 32'd4);

      // 4: framing errors
      send(8'hEE, 1'b0, 0, 0);
      idle(2);
      chk("t4_nosof", 32'(err_nosof), 32'd1);
      chk("t4_sof_clear", 32'(err_sof), 32'd0);
      send(8'h11, 1'b1, 2, 0);
      send(8'h22, 1'b1, 5, 0);
      send(8'h33, 1'b0, 0, 0);
      idle(6);
      chk("t4_sof", 32'(err_sof), 32'd1);
      chk("t4_fc", 32'(frame_cnt), 32'd5);

      // 5: minimum-length frame
      send(8'hB5, 1'b1, 0, 0);
      idle(1);
      chk("t5_beat", 32'({valid, first, last, data}), 32'({3'b111, 8'hB5}));
      idle(4);
      chk("t5_fc", 32'(frame_cnt), 32'd6);

      // 6: reset mid-frame
      for (int i = 0; i < 5; i++) send(8'(8'h60 + i), (i == 0), 9, 0);
      rst = 1'b0;
      #1;
      chk("t6_valid", 32'(valid), 32'd0);
      chk("t6_outs", 32'({first, last, data}), 32'd0);
      chk("t6_fc", 32'(frame_cnt), 32'd0);
      chk("t6_errs", 32'({err_nosof, err_sof}), 32'd0);
      chk("t6_ready", 32'(s_ready), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      send(8'h9A, 1'b1, 1, 0);
      send(8'h9B, 1'b0, 0, 0);
      idle(6);
      chk("t6_fc_after", 32'(frame_cnt), 32'd1);
      chk("t6_drained", 32'(exp_q.size()), 32'd0);

      // Randomized frames with random hold, bubbles and occasional errors
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(0, 19);
         if ($urandom_range(0, 7) == 0) send(8'($urandom), 1'b0, 0, 1);
         for (int b = 0; b <= len; b++) begin
            logic sof;
            sof = (b == 0) || ($urandom_range(0, 9) == 0);
            send(8'($urandom), sof, len, 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      hold = 1'b0;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) idle(1);
      idle(GAP + 3);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
